// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and constants for the A2D SPI responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } resp_state_t;

    localparam int FRAME_W    = 16;
    localparam int CMD_CH_MSB = 13;
    localparam int CMD_CH_LSB = 11;
    localparam int CH_W       = 3;
    localparam int BCNT_W     = 5;

    // Well-known channel codes on the board.
    localparam logic [CH_W-1:0] LFT_LD_CH  = 3'd0;
    localparam logic [CH_W-1:0] RGHT_LD_CH = 3'd4;
    localparam logic [CH_W-1:0] BATT_CH    = 3'd5;

    // Channel-select field of a command frame.
    function automatic logic [CH_W-1:0] cmd_chan(input logic [FRAME_W-1:0] cmd);
        return cmd[CMD_CH_MSB:CMD_CH_LSB];
    endfunction

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between the A2D master and the responder.
// Latency: none (wires only).
// Backpressure: none; SPI has no flow control.
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp_sync_edge.sv
// 2-flop synchronizer plus a third flop giving single-clk rise/fall pulses.
// Latency: pulse appears 2 clk after the raw input edge is first sampled.
// Backpressure: none. Ports: clk, rst (sync, high), din (async), rise, fall.
module spi_sync_edge #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
            s3_q <= IDLE_LVL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/a2d_spi_resp.sv
// SPI mode-0 responder modelling an 8-channel ADC; returns the channel chosen by the previous frame.
// Latency: MISO MSB 4 clk after raw SS_n fall; cmd_vld/frm_err 4 clk after raw SS_n rise.
// Backpressure: none. Ports: clk, rst, spi (slave pins), ch_data, last_cmd, cmd_vld, frm_err, frm_cnt.
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    a2d_spi_resp_if.slave            spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [FRAME_W-1:0]       last_cmd,
    output logic                     cmd_vld,
    output logic                     frm_err,
    output logic [15:0]              frm_cnt
);
    resp_state_t          state_q, state_d;
    logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   rx_shft_q, rx_shft_d;
    logic [FRAME_W-1:0]   tx_shft_q, tx_shft_d;
    logic [CH_W-1:0]      sel_ch_q, sel_ch_d;
    logic [FRAME_W-1:0]   last_cmd_q, last_cmd_d;
    logic                 cmd_vld_q, cmd_vld_d;
    logic                 frm_err_q, frm_err_d;
    logic [15:0]          frm_cnt_q, frm_cnt_d;
    logic                 miso_q, miso_d;
    logic                 mosi_s1_q, mosi_s1_d;
    logic                 mosi_s2_q, mosi_s2_d;
    // Counts clocks since reset release; an SS_n fall is only honoured once the
    // synchronizer holds real pin values, so a frame already running is not joined.
    logic [1:0]           arm_cnt_q, arm_cnt_d;

    logic ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [DATA_W-1:0] ch_sel_dat;

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_ss_sync (
        .clk (clk), .rst (rst), .din (spi.SS_n), .rise (ss_rise), .fall (ss_fall)
    );

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_sclk_sync (
        .clk (clk), .rst (rst), .din (spi.SCLK), .rise (sclk_rise), .fall (sclk_fall)
    );

    assign ch_sel_dat = ch_data[sel_ch_q*DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shft_d  = rx_shft_q;
        tx_shft_d  = tx_shft_q;
        sel_ch_d   = sel_ch_q;
        last_cmd_d = last_cmd_q;
        frm_cnt_d  = frm_cnt_q;
        cmd_vld_d  = 1'b0;
        frm_err_d  = 1'b0;
        mosi_s1_d  = spi.MOSI;
        mosi_s2_d  = mosi_s1_q;
        arm_cnt_d  = (arm_cnt_q == 2'd3) ? 2'd3 : arm_cnt_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (ss_fall && arm_cnt_q == 2'd3) state_d = LOAD;
            end
            LOAD: begin
                tx_shft_d = {{(FRAME_W-DATA_W){1'b0}}, ch_sel_dat};
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // SS_n rise takes priority over any coincident SCLK edge.
                if (ss_rise) begin
                    state_d = DONE;
                end else begin
                    if (sclk_rise) begin
                        rx_shft_d = {rx_shft_q[FRAME_W-2:0], mosi_s2_q};
                        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // The falling edge before the first rise must not consume the MSB.
                    if (sclk_fall && bit_cnt_q != '0) begin
                        tx_shft_d = {tx_shft_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (bit_cnt_q == BCNT_W'(FRAME_W)) begin
                    last_cmd_d = rx_shft_q;
                    sel_ch_d   = cmd_chan(rx_shft_q);
                    cmd_vld_d  = 1'b1;
                    frm_cnt_d  = frm_cnt_q + 16'd1;
                end else begin
                    frm_err_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d == SHIFT) ? tx_shft_d[FRAME_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shft_q  <= '0;
            tx_shft_q  <= '0;
            sel_ch_q   <= '0;
            last_cmd_q <= '0;
            cmd_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            frm_cnt_q  <= '0;
            miso_q     <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            arm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shft_q  <= rx_shft_d;
            tx_shft_q  <= tx_shft_d;
            sel_ch_q   <= sel_ch_d;
            last_cmd_q <= last_cmd_d;
            cmd_vld_q  <= cmd_vld_d;
            frm_err_q  <= frm_err_d;
            frm_cnt_q  <= frm_cnt_d;
            miso_q     <= miso_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign spi.MISO = miso_q;
    assign last_cmd = last_cmd_q;
    assign cmd_vld  = cmd_vld_q;
    assign frm_err  = frm_err_q;
    assign frm_cnt  = frm_cnt_q;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: drives SPI frames as a mode-0 master and checks against a frame-level model.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_a2d_spi_resp;
    import a2d_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a2d_spi_resp_if spi ();

    logic [11:0] ch_vals [8];
    logic [95:0] ch_data;
    logic [15:0] last_cmd, frm_cnt;
    logic        cmd_vld, frm_err;

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = ch_vals[k];
    end

    a2d_spi_resp #(.NUM_CH(8), .DATA_W(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi      (spi),
        .ch_data  (ch_data),
        .last_cmd (last_cmd),
        .cmd_vld  (cmd_vld),
        .frm_err  (frm_err),
        .frm_cnt  (frm_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int vld_seen = 0;
    int err_seen = 0;

    // Frame-level reference state.
    int          m_prev_ch;
    logic [15:0] m_last;
    logic [15:0] m_cnt;
    int          m_vld;
    int          m_err;

    always @(negedge clk) begin
        if (cmd_vld === 1'b1) vld_seen++;
        if (frm_err === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: MOSI changes with SCLK low, MISO sampled as SCLK rises.
    task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_at,
                         input int rst_at, output logic [15:0] rd);
        rd = '0;
        spi.SS_n = 1'b0;
        spi.MOSI = cmd[15];
        clks(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                clks(2);
                rst = 1'b0;
            end
            spi.SCLK = 1'b1;
            if (i < 16) rd[15-i] = spi.MISO;
            clks(6);
            spi.SCLK = 1'b0;
            spi.MOSI = (i < 15) ? cmd[14-i] : 1'b0;
            if (i == chg_at) ch_vals[0] = 12'h222;
            clks(6);
        end
        spi.SS_n = 1'b1;
        clks(10);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits, input int chg_at);
        logic [15:0] exp_rd;
        logic [15:0] rd;
        exp_rd = {4'h0, ch_vals[m_prev_ch]};
        frame(cmd, nbits, chg_at, -1, rd);
        if (nbits == 16) begin
            chk({tag, "_rd"}, 32'(rd), 32'(exp_rd));
            m_vld++;
            m_last    = cmd;
            m_cnt     = m_cnt + 16'd1;
            m_prev_ch = int'(cmd[13:11]);
        end else begin
            m_err++;
        end
        chk({tag, "_vld"}, 32'(vld_seen), 32'(m_vld));
        chk({tag, "_err"}, 32'(err_seen), 32'(m_err));
        chk({tag, "_last"}, 32'(last_cmd), 32'(m_last));
        chk({tag, "_cnt"}, 32'(frm_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [15:0] rd;
        int          nb;

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        rst      = 1'b1;
        for (int k = 0; k < 8; k++) ch_vals[k] = 12'($urandom);
        ch_vals[0] = 12'hABC;
        m_prev_ch = 0; m_last = '0; m_cnt = '0; m_vld = 0; m_err = 0;

        clks(2);
        chk("rst_miso", 32'(spi.MISO), 32'd0);
        chk("rst_last", 32'(last_cmd), 32'd0);
        chk("rst_cnt", 32'(frm_cnt), 32'd0);
        chk("rst_vld", 32'(cmd_vld), 32'd0);
        chk("rst_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        clks(4);

        run_frame("first", 16'h2000, 16, -1);
        ch_vals[4] = 12'h123;
        run_frame("ch4", 16'h2000, 16, -1);
        run_frame("sel5", 16'h2800, 16, -1);
        ch_vals[5] = 12'hFFF;
        run_frame("batt", 16'h0000, 16, -1);

        run_frame("short9", 16'($urandom), 9, -1);
        run_frame("after_short", 16'h0000, 16, -1);

        ch_vals[0] = 12'h111;
        run_frame("chg_mid", 16'h0000, 16, 5);

        // Reset after 7 bits: frame discarded, everything back to reset values.
        frame(16'h2800, 16, -1, 7, rd);
        m_prev_ch = 0; m_last = '0; m_cnt = '0;
        chk("rstmid_miso", 32'(rd[8:0]), 32'd0);
        chk("rstmid_vld", 32'(vld_seen), 32'(m_vld));
        chk("rstmid_err", 32'(err_seen), 32'(m_err));
        chk("rstmid_last", 32'(last_cmd), 32'd0);
        chk("rstmid_cnt", 32'(frm_cnt), 32'd0);
        run_frame("post_rst", 16'($urandom), 16, -1);

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 8; k++) if ($urandom_range(0, 1) == 1) ch_vals[k] = 12'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            run_frame("rand", 16'($urandom), nb, -1);
        end

        force dut.frm_cnt_q = 16'hFFFF;
        clks(2);
        release dut.frm_cnt_q;
        clks(1);
        m_cnt = 16'hFFFF;
        chk("preload_cnt", 32'(frm_cnt), 32'h0000FFFF);
        run_frame("wrap", 16'($urandom), 16, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
